// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the Fibonacci stream generator.
//   fib_state_e : controller states (IDLE, RUN, FIN)
//   MODE_WRAP   : sums that overflow keep their low N bits
//   MODE_SAT    : sums that overflow clamp to all ones
`timescale 1ns/1ps
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fib_state_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/fib_add_sat.sv
// fib_add_sat: combinational N-bit adder with wrap or saturate overflow.
//   a, b  : addends
//   mode  : MODE_WRAP or MODE_SAT
//   sum   : low N bits of a+b, or all ones when saturating on carry
//   ovf   : carry out of the N-bit add (set in both modes)
`timescale 1ns/1ps
module fib_add_sat
  import fib_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mode,
  output logic [N-1:0] sum,
  output logic         ovf
);

  logic [N:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    ovf = full_sum[N];
    sum = full_sum[N-1:0];
    if (full_sum[N] && (mode == MODE_SAT)) begin
      sum = {N{1'b1}};
    end
  end

endmodule

// File: rtl/fib_stream_gen.sv
// fib_stream_gen: streams `length` Fibonacci-style terms seeded by f0/f1.
//   clock, reset     : system clock, asynchronous active-low reset
//   start            : one-cycle request, taken only in IDLE
//   length, f0, f1,
//   mode_sat         : run parameters sampled with start
//   ready            : consumer accepts fn this cycle
//   fn, index, valid : current term, its position, term present
//   busy             : high while terms are being streamed
//   done             : one-cycle pulse once the run has finished
//   overflow         : sticky, some transferred term was wrapped/saturated
//   dbg_state        : current controller state
//
// Handshake: a term moves when valid && ready on a rising clock edge.
// Once valid is high, fn and index stay stable and valid stays high until
// that transfer happens; ready may toggle freely and never affects valid.
`timescale 1ns/1ps
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int N     = 6,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic [N-1:0]     f0,
  input  logic [N-1:0]     f1,
  input  logic             mode_sat,
  input  logic             ready,
  output logic [N-1:0]     fn,
  output logic             valid,
  output logic [CNT_W-1:0] index,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fib_state_e       state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic             a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0] index_q, index_d, len_q, len_d;
  logic             mode_q, mode_d;
  logic             overflow_q, overflow_d;

  logic [N-1:0]     sum;
  logic             sum_ovf;

  fib_add_sat #(.N(N)) u_add (
    .a    (a_q),
    .b    (b_q),
    .mode (mode_q),
    .sum  (sum),
    .ovf  (sum_ovf)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_ovf_d    = a_ovf_q;
    b_ovf_d    = b_ovf_q;
    index_d    = index_q;
    len_d      = len_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = f0;
          b_d        = f1;
          a_ovf_d    = 1'b0;
          b_ovf_d    = 1'b0;
          index_d    = '0;
          len_d      = length;
          mode_d     = mode_sat;
          overflow_d = 1'b0;
          state_d    = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (ready) begin
          a_d        = b_q;
          a_ovf_d    = b_ovf_q;
          b_d        = sum;
          b_ovf_d    = sum_ovf;
          // Only the term leaving now (a) contributes to the sticky flag;
          // clipped sums still waiting in b never reach the consumer.
          overflow_d = overflow_q | a_ovf_q;
          if (index_q == len_q - CNT_ONE) begin
            state_d = FIN;
          end else begin
            index_d = index_q + CNT_ONE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      a_ovf_q    <= 1'b0;
      b_ovf_q    <= 1'b0;
      index_q    <= '0;
      len_q      <= '0;
      mode_q     <= MODE_WRAP;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_ovf_q    <= a_ovf_d;
      b_ovf_q    <= b_ovf_d;
      index_q    <= index_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
    end
  end

  assign fn        = a_q;
  assign index     = index_q;
  assign valid     = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
